rtor_activity_monitor: RTL and testbench
========================================

Name: rtor_activity_monitor

Overview:
- Downstream consumer of the register-to-register test stage's registered output `f`. `f` comes straight from a DFFPOSX1, so it is synchronous to `clk`.
- Samples `f` over fixed windows of WIN_LEN cycles and counts high cycles and rising edges per window.
- Publishes one report per window on a valid/ready interface, with a sticky overrun flag.
- Provides measured switching activity for the timing/power regression benches.

Parameters:
- WIN_LEN, 16: cycles per window. Legal range 2..2^CNT_W-1.
- CNT_W, 5: width of the count fields. Counts saturate at 2^CNT_W-1.

Ports:
- clk  in  1  clock. All state is on the rising edge.
- rst  in  1  reset, asynchronous, active-low.
- en  in  1  monitor enable.
- f  in  1  observed signal (registered upstream).
- rpt_ready  in  1  consumer accepts the report.
- rpt_valid  out  1  report available.
- rpt_ones  out  CNT_W  number of cycles in the window with f=1.
- rpt_rises  out  CNT_W  number of 0->1 transitions of f in the window.
- overrun  out  1  sticky: a window end was dropped.
- clr_overrun  in  1  synchronous clear of overrun.

Behaviour:
- Reset (rst=0), asynchronous:
  - state=IDLE.
  - win_cnt, ones_acc, rise_acc, f_prev = 0.
  - rpt_valid=0, rpt_ones=0, rpt_rises=0, overrun=0.
  - Outputs go to 0 immediately, without waiting for a clock edge.
- f_prev <= f on every clock outside reset, in every state.
  - rise_now = f & ~f_prev.
  - A rise across a window boundary, or on the first RUN cycle, is counted in the window containing the 1 sample.
- FSM:
  - IDLE -> RUN when en=1. The first sampled cycle is the cycle after en is seen.
  - RUN -> IDLE when en=0. The partial window is discarded and accumulators are zeroed. A pending report is kept until handshaked.
- In RUN, every cycle:
  - ones_acc += f and rise_acc += rise_now, both saturating at 2^CNT_W-1.
  - win_cnt increments.
- Window end (RUN and win_cnt==WIN_LEN-1):
  - Final counts include the current cycle's sample.
  - win_cnt, ones_acc and rise_acc restart at 0 next cycle; the next window starts immediately.
  - If rpt_valid=0 or (rpt_valid&rpt_ready) this cycle: load rpt_ones/rpt_rises, and rpt_valid=1 next cycle. Latency is 1 cycle from the last sample.
  - Otherwise (valid&!ready): set overrun=1, keep the old report unchanged, and drop the new window's counts.
- Handshake:
  - Transfer occurs on the cycle with rpt_valid&rpt_ready.
  - rpt_valid clears next cycle unless a window end loads a new report on the same cycle, in which case rpt_valid stays 1 with the new data.
  - rpt_ones/rpt_rises are stable while valid&!ready.
- overrun:
  - Set on a dropped window. Cleared by clr_overrun.
  - If set and clear occur on the same cycle, set wins.
- en toggling with rpt_valid=1 has no effect on rpt_valid or the report registers.

Decomposition:
- Package rtor_pkg:
  - state enum {IDLE, RUN}.
  - WIN_LEN/CNT_W defaults.
  - function cnt_sat_inc(value, inc) for saturating increment.
- One natural sub-module, rtor_sat_acc: a CNT_W saturating accumulator with synchronous zero and 1-bit increment. Instantiate it twice (ones, rises).
- The edge detect and the FSM stay in the top level.

Test Plan (WIN_LEN=8, CNT_W=5 unless stated):
1. Hold rst=0 with f=1 and en=1, then release -> all outputs 0 during reset. The first report arrives 9 cycles after en is sampled.
2. f_prev=0; f alternates 1,0,1,0,... for 8 RUN cycles; rpt_ready=1 -> rpt_valid high for 1 cycle with rpt_ones=4, rpt_rises=4, overrun=0.
3. f held 1 for 16 RUN cycles from f_prev=0 -> report 1 is ones=8, rises=1. Report 2 is ones=8, rises=0.
4. rpt_ready=0 across two window ends, data (ones=3, rises=2) then (ones=8, ...) -> overrun=1 and the report still shows 3/2. Assert ready -> transfer. clr_overrun -> overrun=0.
5. en dropped after 3 RUN cycles with f=1, then re-enabled -> no report for the partial window. The next report covers 8 fresh cycles (ones=8, rises=0).
6. rst asserted mid-window while rpt_valid=1 -> rpt_valid, rpt_ones and overrun go 0 before the next clk edge.

Source files
------------

// File: rtl/rtor_pkg.sv
// Shared types and helpers for the rtor activity monitor.
package rtor_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  localparam int WIN_LEN_DEF = 16;
  localparam int CNT_W_DEF   = 5;

  // Increment by a single bit, holding at the all-ones value of a width-bit counter.
  function automatic logic [31:0] cnt_sat_inc(input logic [31:0] value, input logic inc,
                                              input int unsigned width);
    logic [31:0] max_v;
    max_v = (32'd1 << width) - 32'd1;
    if (value >= max_v) return max_v;
    return value + {31'd0, inc};
  endfunction

endpackage

// File: rtl/rtor_sat_acc.sv
// Saturating CNT_W-bit accumulator with synchronous zero and a 1-bit increment.
module rtor_sat_acc
  import rtor_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             inc,
  output logic [CNT_W-1:0] acc_next
);

  logic [CNT_W-1:0] acc;

  // acc_next already includes this cycle's increment so a window end can report it directly.
  assign acc_next = CNT_W'(cnt_sat_inc(32'(acc), inc, CNT_W));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      acc <= '0;
    end else if (clr) begin
      acc <= '0;
    end else begin
      acc <= acc_next;
    end
  end

endmodule

// File: rtl/rtor_activity_monitor.sv
// Windowed high-cycle and rising-edge counter for f, reporting over valid/ready
// with a sticky overrun flag when a window report cannot be accepted.
module rtor_activity_monitor
  import rtor_pkg::*;
#(
  parameter int WIN_LEN = WIN_LEN_DEF,
  parameter int CNT_W   = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             f,
  input  logic             rpt_ready,
  output logic             rpt_valid,
  output logic [CNT_W-1:0] rpt_ones,
  output logic [CNT_W-1:0] rpt_rises,
  output logic             overrun,
  input  logic             clr_overrun
);

  localparam logic [CNT_W-1:0] WIN_LAST = CNT_W'(WIN_LEN - 1);

  state_t           state;
  logic [CNT_W-1:0] win_cnt;
  logic             f_prev;
  logic             rise_now;
  logic             sample;
  logic             win_end;
  logic             acc_clr;
  logic             xfer;
  logic             load;
  logic             drop;
  logic [CNT_W-1:0] ones_next;
  logic [CNT_W-1:0] rises_next;

  assign rise_now = f & ~f_prev;
  // A RUN cycle with en low leaves the window rather than sampling into it.
  assign sample   = (state == RUN) && en;
  assign win_end  = sample && (win_cnt == WIN_LAST);
  assign acc_clr  = !sample || win_end;
  assign xfer     = rpt_valid && rpt_ready;
  assign load     = win_end && (!rpt_valid || rpt_ready);
  assign drop     = win_end && rpt_valid && !rpt_ready;

  rtor_sat_acc #(.CNT_W(CNT_W)) u_ones_acc (
    .clk      (clk),
    .rst      (rst),
    .clr      (acc_clr),
    .inc      (f),
    .acc_next (ones_next)
  );

  rtor_sat_acc #(.CNT_W(CNT_W)) u_rise_acc (
    .clk      (clk),
    .rst      (rst),
    .clr      (acc_clr),
    .inc      (rise_now),
    .acc_next (rises_next)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      win_cnt   <= '0;
      f_prev    <= 1'b0;
      rpt_valid <= 1'b0;
      rpt_ones  <= '0;
      rpt_rises <= '0;
      overrun   <= 1'b0;
    end else begin
      f_prev <= f;

      case (state)
        IDLE: begin
          win_cnt <= '0;
          if (en) state <= RUN;
        end
        RUN: begin
          if (!en) begin
            state   <= IDLE;
            win_cnt <= '0;
          end else if (win_end) begin
            win_cnt <= '0;
          end else begin
            win_cnt <= win_cnt + CNT_W'(1);
          end
        end
        default: begin
          state   <= IDLE;
          win_cnt <= '0;
        end
      endcase

      // A new report may replace one that is handed off on the same edge.
      if (load) begin
        rpt_valid <= 1'b1;
        rpt_ones  <= ones_next;
        rpt_rises <= rises_next;
      end else if (xfer) begin
        rpt_valid <= 1'b0;
      end

      if (drop) begin
        overrun <= 1'b1;
      end else if (clr_overrun) begin
        overrun <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_rtor_activity_monitor.sv
// Directed scoreboard bench for rtor_activity_monitor with WIN_LEN=8, CNT_W=5.
module tb_rtor_activity_monitor;

  localparam int WIN_LEN = 8;
  localparam int CNT_W   = 5;

  typedef struct packed {
    logic [CNT_W-1:0] ones;
    logic [CNT_W-1:0] rises;
  } rpt_t;

  logic             clk = 1'b0;
  logic             rst;
  logic             en;
  logic             f;
  logic             rpt_ready;
  logic             clr_overrun;
  logic             rpt_valid;
  logic [CNT_W-1:0] rpt_ones;
  logic [CNT_W-1:0] rpt_rises;
  logic             overrun;

  int   tests_run    = 0;
  int   tests_failed = 0;
  rpt_t sb[$];
  rpt_t mon_exp;

  always #5 clk = ~clk;

  rtor_activity_monitor #(.WIN_LEN(WIN_LEN), .CNT_W(CNT_W)) dut (
    .clk         (clk),
    .rst         (rst),
    .en          (en),
    .f           (f),
    .rpt_ready   (rpt_ready),
    .rpt_valid   (rpt_valid),
    .rpt_ones    (rpt_ones),
    .rpt_rises   (rpt_rises),
    .overrun     (overrun),
    .clr_overrun (clr_overrun)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Every accepted report is matched against the oldest expected one.
  always @(negedge clk) begin
    if (rst === 1'b1 && rpt_valid === 1'b1 && rpt_ready === 1'b1) begin
      tests_run++;
      assert (sb.size() != 0) else begin
        tests_failed++;
        $error("FAIL sb_unexpected: observed report %0d/%0d expected none", rpt_ones, rpt_rises);
      end
      if (sb.size() != 0) begin
        mon_exp = sb.pop_front();
        check("rpt_ones", 32'(rpt_ones), 32'(mon_exp.ones));
        check("rpt_rises", 32'(rpt_rises), 32'(mon_exp.rises));
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic start_run(input logic fv);
    en = 1'b1;
    f  = fv;
    cyc();
  endtask

  task automatic stop_run();
    en = 1'b0;
    cyc();
  endtask

  // Drives one full window (bit 0 first); the previous f is whatever is held now.
  task automatic run_win(input logic [7:0] pat, input bit push);
    int   ones;
    int   rises;
    logic p;
    rpt_t r;
    ones  = 0;
    rises = 0;
    p     = f;
    for (int i = 0; i < WIN_LEN; i++) begin
      if (pat[i]) ones++;
      if (pat[i] && !p) rises++;
      p = pat[i];
    end
    r.ones  = CNT_W'(ones);
    r.rises = CNT_W'(rises);
    if (push) sb.push_back(r);
    for (int i = 0; i < WIN_LEN; i++) begin
      f = pat[i];
      cyc();
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "bench timeout");
  end

  initial begin
    // Reset held with f and en high
    rst = 1'b0; en = 1'b1; f = 1'b1; rpt_ready = 1'b1; clr_overrun = 1'b0;
    #2;
    check("reset_valid", 32'(rpt_valid), 0);
    check("reset_ones", 32'(rpt_ones), 0);
    check("reset_rises", 32'(rpt_rises), 0);
    check("reset_overrun", 32'(overrun), 0);
    repeat (2) cyc();
    check("reset_hold_valid", 32'(rpt_valid), 0);
    rst = 1'b1;
    r1_push();
    repeat (8) cyc();
    check("t1_not_yet", 32'(rpt_valid), 0);
    cyc();
    check("t1_valid_at_9", 32'(rpt_valid), 1);
    stop_run();
    check("t1_cleared", 32'(rpt_valid), 0);

    // Alternating f
    start_run(1'b0);
    run_win(8'b0101_0101, 1'b1);
    check("t2_valid", 32'(rpt_valid), 1);
    check("t2_overrun", 32'(overrun), 0);
    stop_run();
    check("t2_one_cycle", 32'(rpt_valid), 0);

    // f held high across two windows
    start_run(1'b0);
    run_win(8'hFF, 1'b1);
    run_win(8'hFF, 1'b1);
    stop_run();
    check("t3_cleared", 32'(rpt_valid), 0);

    // Back-pressure across two window ends
    rpt_ready = 1'b0;
    start_run(1'b0);
    run_win(8'b0000_1011, 1'b1);
    check("t4_valid_a", 32'(rpt_valid), 1);
    check("t4_no_overrun_yet", 32'(overrun), 0);
    run_win(8'hFF, 1'b0);
    check("t4_overrun", 32'(overrun), 1);
    check("t4_held_ones", 32'(rpt_ones), 3);
    check("t4_held_rises", 32'(rpt_rises), 2);
    stop_run();
    en = 1'b1; cyc();
    en = 1'b0; cyc();
    check("t4_en_toggle_valid", 32'(rpt_valid), 1);
    check("t4_en_toggle_ones", 32'(rpt_ones), 3);
    rpt_ready = 1'b1;
    cyc();
    check("t4_xfer_cleared", 32'(rpt_valid), 0);
    check("t4_overrun_sticky", 32'(overrun), 1);
    clr_overrun = 1'b1; cyc(); clr_overrun = 1'b0;
    check("t4_overrun_clr", 32'(overrun), 0);

    // Drop and clear on the same edge: set wins
    rpt_ready = 1'b0;
    start_run(1'b0);
    run_win(8'h01, 1'b1);
    clr_overrun = 1'b1;
    run_win(8'h00, 1'b0);
    clr_overrun = 1'b0;
    check("t4b_set_wins", 32'(overrun), 1);
    rpt_ready = 1'b1;
    stop_run();
    check("t4b_cleared", 32'(rpt_valid), 0);
    clr_overrun = 1'b1; cyc(); clr_overrun = 1'b0;
    check("t4b_overrun_clr", 32'(overrun), 0);

    // Partial window discarded when en drops
    start_run(1'b1);
    repeat (3) cyc();
    en = 1'b0;
    cyc();
    check("t5_no_partial", 32'(rpt_valid), 0);
    start_run(1'b1);
    run_win(8'hFF, 1'b1);
    stop_run();
    check("t5_cleared", 32'(rpt_valid), 0);

    // Asynchronous reset mid-window with a pending report
    rpt_ready = 1'b0;
    start_run(1'b0);
    run_win(8'h07, 1'b0);
    run_win(8'hFF, 1'b0);
    repeat (3) cyc();
    check("t6_pre_valid", 32'(rpt_valid), 1);
    check("t6_pre_ones", 32'(rpt_ones), 3);
    check("t6_pre_overrun", 32'(overrun), 1);
    #2 rst = 1'b0;
    #1;
    check("t6_async_valid", 32'(rpt_valid), 0);
    check("t6_async_ones", 32'(rpt_ones), 0);
    check("t6_async_rises", 32'(rpt_rises), 0);
    check("t6_async_overrun", 32'(overrun), 0);
    cyc();
    rst = 1'b1; en = 1'b0;
    cyc();
    check("t6_after_release", 32'(rpt_valid), 0);

    check("sb_empty", 32'(sb.size()), 0);
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  // First window after reset release: f_prev already high, so no rise is counted.
  task automatic r1_push();
    rpt_t r;
    r.ones  = CNT_W'(8);
    r.rises = CNT_W'(0);
    sb.push_back(r);
  endtask

endmodule
